// File: rtl/linear_net_sequencer.sv
// Runs a multi-layer fully connected network on one layer engine: fetches a
// per-layer descriptor, programs the engine's base addresses, starts it and waits.
module linear_net_sequencer #(
    parameter int ADDR_WIDTH      = 8,
    parameter int DATABUS_WIDTH   = 32,
    parameter int LAYER_CNT_WIDTH = 4,
    parameter int TIMEOUT         = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      desc_base,
    input  logic [LAYER_CNT_WIDTH-1:0] num_layers,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [LAYER_CNT_WIDTH-1:0] layer_idx,
    output logic                       layer_start,
    output logic [ADDR_WIDTH-1:0]      layer_activ_base,
    output logic [ADDR_WIDTH-1:0]      layer_weight_base,
    output logic [ADDR_WIDTH-1:0]      layer_bias_base,
    output logic [ADDR_WIDTH-1:0]      layer_output_base,
    input  logic                       layer_done,
    input  logic                       layer_mem_sel,
    input  logic                       layer_mem_w,
    input  logic [ADDR_WIDTH-1:0]      layer_address,
    output logic                       mem_sel,
    output logic                       mem_w,
    output logic [ADDR_WIDTH-1:0]      address_bus,
    input  logic [DATABUS_WIDTH-1:0]   data_bus,
    input  logic                       ready
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, FETCH, LAUNCH, RUN, FIN} state_t;

    state_t                     state, state_nx;
    logic [ADDR_WIDTH-1:0]      desc_base_q;
    logic [LAYER_CNT_WIDTH-1:0] num_layers_q;
    logic [LAYER_CNT_WIDTH-1:0] idx_nx;
    logic                       seq_sel;
    logic [ADDR_WIDTH-1:0]      seq_addr;
    logic [WD_W-1:0]            wdog;
    logic                       wdog_exp;
    logic                       last_layer;

    assign wdog_exp   = (wdog == WD_W'(TIMEOUT - 1));
    assign last_layer = (layer_idx == num_layers_q - LAYER_CNT_WIDTH'(1));
    assign idx_nx     = layer_idx + LAYER_CNT_WIDTH'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (num_layers == '0) ? FIN : FETCH;
            FETCH:   if (ready) state_nx = LAUNCH;
                     else if (wdog_exp) state_nx = FIN;
            LAUNCH:  state_nx = RUN;
            RUN:     if (layer_done) state_nx = last_layer ? FIN : FETCH;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            desc_base_q       <= '0;
            num_layers_q      <= '0;
            layer_idx         <= '0;
            seq_sel           <= 1'b0;
            seq_addr          <= '0;
            wdog              <= '0;
            err               <= 1'b0;
            layer_activ_base  <= '0;
            layer_weight_base <= '0;
            layer_bias_base   <= '0;
            layer_output_base <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    desc_base_q  <= desc_base;
                    num_layers_q <= num_layers;
                    err          <= 1'b0;
                    layer_idx    <= '0;
                    wdog         <= '0;
                    if (num_layers != '0) begin
                        seq_sel  <= 1'b1;
                        seq_addr <= desc_base;
                    end
                end
                FETCH: begin
                    if (ready) begin
                        layer_activ_base  <= data_bus[0*ADDR_WIDTH +: ADDR_WIDTH];
                        layer_weight_base <= data_bus[1*ADDR_WIDTH +: ADDR_WIDTH];
                        layer_bias_base   <= data_bus[2*ADDR_WIDTH +: ADDR_WIDTH];
                        layer_output_base <= data_bus[3*ADDR_WIDTH +: ADDR_WIDTH];
                        seq_sel           <= 1'b0;
                    end else if (wdog_exp) begin
                        err     <= 1'b1;
                        seq_sel <= 1'b0;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                RUN: if (layer_done && !last_layer) begin
                    // address is prepared here so the bus request leaves one edge after done
                    layer_idx <= idx_nx;
                    seq_sel   <= 1'b1;
                    seq_addr  <= desc_base_q + ADDR_WIDTH'(idx_nx);
                    wdog      <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign done        = (state == FIN);
    assign layer_start = (state == LAUNCH);

    // the bus belongs to the engine except while a descriptor is being fetched
    always_comb begin
        mem_sel     = layer_mem_sel;
        mem_w       = layer_mem_w;
        address_bus = layer_address;
        if (state == FETCH) begin
            mem_sel     = seq_sel;
            mem_w       = 1'b0;
            address_bus = seq_addr;
        end
    end

endmodule

// File: tb/tb_linear_net_sequencer.sv
// Directed bench for linear_net_sequencer: combinational-ready memory model,
// engine side driven by hand.
module tb_linear_net_sequencer;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  desc_base = '0;
    logic [3:0]  num_layers = '0;
    logic        busy, done, err, layer_start;
    logic [3:0]  layer_idx;
    logic [7:0]  act_b, wgt_b, bia_b, out_b;
    logic        layer_done = 1'b0;
    logic        layer_mem_sel = 1'b0;
    logic        layer_mem_w = 1'b0;
    logic [7:0]  layer_address = '0;
    logic        mem_sel, mem_w;
    logic [7:0]  address_bus;
    logic [31:0] data_bus;
    logic        ready;
    logic        ready_en = 1'b1;

    logic [31:0] mem_arr [256];
    int          checks = 0;
    int          errors = 0;
    int          ls_cnt = 0;
    int          done_cnt = 0;
    int          sel_cnt = 0;
    logic [7:0]  fetch_q [$];

    linear_net_sequencer #(.ADDR_WIDTH(8), .DATABUS_WIDTH(32), .LAYER_CNT_WIDTH(4), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .desc_base(desc_base), .num_layers(num_layers),
        .busy(busy), .done(done), .err(err), .layer_idx(layer_idx), .layer_start(layer_start),
        .layer_activ_base(act_b), .layer_weight_base(wgt_b), .layer_bias_base(bia_b),
        .layer_output_base(out_b), .layer_done(layer_done), .layer_mem_sel(layer_mem_sel),
        .layer_mem_w(layer_mem_w), .layer_address(layer_address), .mem_sel(mem_sel),
        .mem_w(mem_w), .address_bus(address_bus), .data_bus(data_bus), .ready(ready)
    );

    always #5 clk = ~clk;

    assign ready    = ready_en & mem_sel & ~mem_w;
    assign data_bus = mem_arr[address_bus];

    always @(negedge clk) begin
        if (layer_start) ls_cnt++;
        if (done) done_cnt++;
        if (mem_sel && !layer_mem_sel) sel_cnt++;
        if (mem_sel && ready && !layer_mem_sel) fetch_q.push_back(address_bus);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clr_mon();
        ls_cnt = 0; done_cnt = 0; sel_cnt = 0;
        fetch_q.delete();
    endtask

    task automatic chk_bases(input string tag, input logic [31:0] exp);
        chk(tag, {out_b, bia_b, wgt_b, act_b}, exp);
    endtask

    task automatic go(input logic [7:0] base, input logic [3:0] n);
        desc_base = base; num_layers = n; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int n;
        bit seen;
        for (int i = 0; i < 256; i++) mem_arr[i] = '0;
        mem_arr[40] = 32'h201C1000;
        mem_arr[41] = 32'h60504020;
        mem_arr[42] = 32'hA0908060;

        // reset state and bus pass-through during reset
        layer_mem_sel = 1'b1; layer_address = 8'h5A; layer_mem_w = 1'b1;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ls", layer_start, 0);
        chk("rst_idx", layer_idx, 0);
        chk_bases("rst_bases", 0);
        chk("rst_passthru", {mem_sel, mem_w, address_bus}, {2'b11, 8'h5A});
        layer_mem_sel = 1'b0; layer_mem_w = 1'b0; layer_address = '0;
        tick();
        rst = 1'b1;
        tick();

        // single layer
        clr_mon();
        go(8'd40, 4'd1);
        chk("s_fetch", {busy, mem_sel, mem_w, address_bus}, {3'b110, 8'd40});
        chk("s_ls_early", layer_start, 0);
        tick();
        chk("s_ls", layer_start, 1);
        chk_bases("s_bases", 32'h201C1000);
        chk("s_bus_free", mem_sel, 0);
        tick();
        layer_mem_sel = 1'b1; layer_mem_w = 1'b1; layer_address = 8'd33;
        #1;
        chk("s_passthru", {mem_sel, mem_w, address_bus}, {2'b11, 8'd33});
        tick();
        layer_mem_sel = 1'b0; layer_mem_w = 1'b0; layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
        chk("s_done", {done, busy}, 2'b11);
        tick();
        chk("s_idle", {done, busy, layer_idx}, 6'b000000);
        chk("s_nfetch", fetch_q.size(), 1);
        chk("s_fetch_addr", fetch_q[0], 40);
        chk("s_ls_cnt", ls_cnt, 1);
        chk("s_done_cnt", done_cnt, 1);

        // three chained layers with spurious start in RUN and layer_done in FETCH
        clr_mon();
        go(8'd40, 4'd3);
        chk("m0_fetch", address_bus, 40);
        tick();
        chk("m0_ls", {layer_start, layer_idx}, 5'b10000);
        chk_bases("m0_bases", 32'h201C1000);
        tick();
        start = 1'b1; desc_base = 8'd99; num_layers = 4'd9;
        tick();
        start = 1'b0;
        chk("m0_spur_start", {busy, layer_start, layer_idx}, 6'b100000);
        chk_bases("m0_keep", 32'h201C1000);
        layer_done = 1'b1; ready_en = 1'b0;
        tick();
        chk("m1_fetch", {mem_sel, address_bus, layer_idx}, {1'b1, 8'd41, 4'd1});
        tick();
        chk("m1_spur_done", {mem_sel, address_bus, layer_idx, layer_start, done}, {1'b1, 8'd41, 4'd1, 2'b00});
        chk_bases("m1_keep", 32'h201C1000);
        layer_done = 1'b0; ready_en = 1'b1;
        tick();
        chk("m1_ls", {layer_start, layer_idx}, 5'b10001);
        chk_bases("m1_bases", 32'h60504020);
        tick();
        layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
        chk("m2_fetch", {mem_sel, address_bus, layer_idx}, {1'b1, 8'd42, 4'd2});
        tick();
        chk("m2_ls", {layer_start, layer_idx}, 5'b10010);
        chk_bases("m2_bases", 32'hA0908060);
        tick();
        layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
        chk("m_done", {done, busy, layer_idx}, {2'b11, 4'd2});
        tick();
        chk("m_idle_hold", {done, busy, layer_idx}, {2'b00, 4'd2});
        chk("m_nfetch", fetch_q.size(), 3);
        chk("m_fetch_seq", {fetch_q[0], fetch_q[1], fetch_q[2]}, {8'd40, 8'd41, 8'd42});
        chk("m_ls_cnt", ls_cnt, 3);
        chk("m_done_cnt", done_cnt, 1);

        // zero layers
        clr_mon();
        go(8'd40, 4'd0);
        chk("z_done", {done, busy, mem_sel}, 3'b110);
        tick();
        chk("z_idle", {done, busy}, 2'b00);
        chk("z_sel_cnt", sel_cnt, 0);
        chk("z_ls_cnt", ls_cnt, 0);
        chk("z_idx", layer_idx, 0);

        // fetch timeout
        clr_mon();
        ready_en = 1'b0;
        go(8'd40, 4'd1);
        n = 1; seen = 1'b0;
        for (int i = 1; i <= TO + 10 && !seen; i++) begin
            if (done) begin seen = 1'b1; n = i; end
            else tick();
        end
        chk("t_seen", seen, 1);
        chk("t_lat", n, TO + 1);
        chk("t_err", err, 1);
        chk("t_ls_cnt", ls_cnt, 0);
        tick();
        chk("t_err_sticky", {err, busy}, 2'b10);
        ready_en = 1'b1;
        go(8'd40, 4'd1);
        chk("t_err_clr", err, 0);
        tick();
        tick();
        layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
        chk("t_good_done", {done, err}, 2'b10);
        tick();

        // reset during RUN of layer 1
        clr_mon();
        go(8'd40, 4'd2);
        tick();
        tick();
        layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
        tick();
        chk("r_l1", {layer_start, layer_idx}, 5'b10001);
        tick();
        rst = 1'b0;
        #1;
        chk("r_busy", busy, 0);
        chk("r_idx", layer_idx, 0);
        chk_bases("r_bases", 0);
        tick();
        rst = 1'b1;
        tick();
        go(8'd40, 4'd2);
        chk("r_restart_fetch", {mem_sel, address_bus, layer_idx}, {1'b1, 8'd40, 4'd0});
        tick();
        chk("r_restart_ls", {layer_start, layer_idx}, 5'b10000);
        chk_bases("r_restart_bases", 32'h201C1000);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
